// File: rtl/csa_accum_stream_pkg.sv
// Shared definitions for the carry-save streaming accumulator: FSM states,
// lane limit and the 3:2 row-count helper.
package csa_pkg;

   localparam int CSA_MAX_LANES = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_FINAL = 2'd2,
      ST_DONE  = 2'd3
   } csa_state_e;

   // Each 3:2 row turns three vectors into two, so n vectors need n-2 rows.
   function automatic int csa_rows(input int n);
      return (n > 2) ? (n - 2) : 0;
   endfunction

endpackage

// File: rtl/csa_accum_stream_if.sv
// Beat-in / result-out handshake bundle for csa_accum_stream.
// out_beats is present only when CSA_ACCUM_BEATCNT_EN is defined.
interface csa_accum_stream_if #(
   parameter int WIDTH = 64,
   parameter int LANES = 15
);

   logic                   in_valid;
   logic                   in_ready;
   logic                   in_last;
   logic [LANES*WIDTH-1:0] in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       out_sum;
`ifdef CSA_ACCUM_BEATCNT_EN
   logic [15:0]            out_beats;
`endif

`ifdef CSA_ACCUM_BEATCNT_EN
   modport master (
      output in_valid, in_last, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_beats
   );

   modport slave (
      input  in_valid, in_last, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_beats
   );
`else
   modport master (
      output in_valid, in_last, in_data, out_ready,
      input  in_ready, out_valid, out_sum
   );

   modport slave (
      input  in_valid, in_last, in_data, out_ready,
      output in_ready, out_valid, out_sum
   );
`endif

endinterface

// File: rtl/csa_accum_stream_row.sv
// One bitwise 3:2 compressor row: sum = a^b^c, carry = majority shifted
// left by one with the top bit dropped (arithmetic is mod 2^WIDTH).
module csa_row #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry
);

   assign sum   = a ^ b ^ c;
   assign carry = {(a[WIDTH-2:0] & b[WIDTH-2:0]) |
                   (a[WIDTH-2:0] & c[WIDTH-2:0]) |
                   (b[WIDTH-2:0] & c[WIDTH-2:0]), 1'b0};

endmodule

// File: rtl/csa_accum_stream.sv
// Streaming multi-operand accumulator: LANES operands per beat folded into a
// redundant sum/carry pair, one CPA on the final beat. Optional beat counter
// out_beats is enabled by defining CSA_ACCUM_BEATCNT_EN.
module csa_accum_stream
   import csa_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int LANES = 15
) (
   input  logic                clk,
   input  logic                rst,
   csa_accum_stream_if.slave   bus
);

   localparam int NVEC  = LANES + 2;
   localparam int NROWS = csa_rows(NVEC);
   localparam int NPOOL = NVEC + 2 * NROWS;

   generate
      if (LANES < 1 || LANES > CSA_MAX_LANES || WIDTH < 4) begin : g_bad_cfg
         $error("csa_accum_stream: unsupported WIDTH/LANES");
      end
   endgenerate

   csa_state_e       state_reg;
   csa_state_e       state_next;
   logic [WIDTH-1:0] sum_reg;
   logic [WIDTH-1:0] carry_reg;
   logic [WIDTH-1:0] out_sum_reg;
   logic [WIDTH-1:0] sum_next;
   logic [WIDTH-1:0] carry_next;
   logic             in_ready_int;
   logic             accept;

   // Vector pool consumed as a queue: row gi reads entries 3gi..3gi+2 and
   // appends two, which yields a Wallace-style tree of depth ~log1.5(NVEC).
   logic [NPOOL-1:0][WIDTH-1:0] pool;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign pool[gi] = bus.in_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // A fresh sum starts from zero regardless of what the registers hold.
   assign pool[LANES]     = (state_reg == ST_ACCUM) ? sum_reg   : '0;
   assign pool[LANES + 1] = (state_reg == ST_ACCUM) ? carry_reg : '0;

   generate
      for (genvar gi = 0; gi < NROWS; gi++) begin : g_row
         csa_row #(.WIDTH(WIDTH)) u_row (
            .a     (pool[3*gi]),
            .b     (pool[3*gi + 1]),
            .c     (pool[3*gi + 2]),
            .sum   (pool[NVEC + 2*gi]),
            .carry (pool[NVEC + 2*gi + 1])
         );
      end
   endgenerate

   assign sum_next   = pool[NPOOL-2];
   assign carry_next = pool[NPOOL-1];

   assign in_ready_int = !rst && ((state_reg == ST_IDLE) || (state_reg == ST_ACCUM));
   assign accept       = bus.in_valid && in_ready_int;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_ACCUM: begin
            if (accept) begin
               state_next = bus.in_last ? ST_FINAL : ST_ACCUM;
            end
         end
         ST_FINAL: state_next = ST_DONE;
         ST_DONE: begin
            if (bus.out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         sum_reg     <= '0;
         carry_reg   <= '0;
         out_sum_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
         end else if (state_reg == ST_DONE && bus.out_ready) begin
            sum_reg   <= '0;
            carry_reg <= '0;
         end
         // The only carry-propagate add lives here, alone in its cycle.
         if (state_reg == ST_FINAL) begin
            out_sum_reg <= sum_reg + carry_reg;
         end
      end
   end

`ifdef CSA_ACCUM_BEATCNT_EN
   logic [15:0] beats_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         beats_reg <= '0;
      end else if (accept) begin
         if (state_reg == ST_IDLE) begin
            beats_reg <= 16'd1;
         end else if (beats_reg != 16'hFFFF) begin
            beats_reg <= beats_reg + 16'd1;
         end
      end
   end

   assign bus.out_beats = beats_reg;
`endif

   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = (state_reg == ST_DONE);
   assign bus.out_sum   = out_sum_reg;

endmodule
